// File: rtl/game_sprite_motion.sv
// Single-sprite motion unit: position/velocity registers, a step divider and an IDLE/RUN/OFF sequencer.
// Define GAME_SPRITE_BOUNCE_EN to make horizontal exits bounce instead of parking the sprite in OFF.
module game_sprite_motion #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int D_W      = 4,
    parameter int STEP_DIV = 1048576,
    parameter int START_X  = 0,
    parameter int START_Y  = 0,
    parameter int START_DX = 0,
    parameter int START_DY = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sprite_write_xy,
    input  logic           sprite_write_dxy,
    input  logic           sprite_enable_update,
    input  logic [X_W-1:0] sprite_write_x,
    input  logic [Y_W-1:0] sprite_write_y,
    input  logic [D_W-1:0] sprite_write_dx,
    input  logic [D_W-1:0] sprite_write_dy,
    output logic [X_W-1:0] sprite_x,
    output logic [Y_W-1:0] sprite_y,
    output logic [D_W-1:0] sprite_dx,
    output logic [D_W-1:0] sprite_dy,
    output logic           sprite_within_screen,
    output logic           sprite_step
);
    localparam int CNT_W = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);
    localparam logic [X_W:0] X_MAX = (X_W + 1)'(SCREEN_W - SPRITE_W);
    localparam logic [Y_W:0] Y_MAX = (Y_W + 1)'(SCREEN_H - SPRITE_H);
    localparam logic START_OK = (START_X >= 0) && (START_X <= SCREEN_W - SPRITE_W) &&
                                (START_Y >= 0) && (START_Y <= SCREEN_H - SPRITE_H);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OFF} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [D_W-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic             within_q, within_d;
    logic             step_q, step_d;

    logic             tick;
    logic [X_W:0]     nx;
    logic [Y_W:0]     ny;
    logic             nx_ok, ny_ok, load_ok;

    // Two's complement sum in one extra bit; the top bit set means the result went negative.
    assign nx = {1'b0, x_q} + {{(X_W + 1 - D_W){dx_q[D_W-1]}}, dx_q};
    assign ny = {1'b0, y_q} + {{(Y_W + 1 - D_W){dy_q[D_W-1]}}, dy_q};
    assign nx_ok = !nx[X_W] && (nx <= X_MAX);
    assign ny_ok = !ny[Y_W] && (ny <= Y_MAX);
    assign load_ok = ({1'b0, sprite_write_x} <= X_MAX) && ({1'b0, sprite_write_y} <= Y_MAX);
    assign tick = (state_q == S_RUN) && sprite_enable_update && (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        within_d = within_q;
        step_d   = 1'b0;

        case (state_q)
            S_IDLE: if (sprite_enable_update) state_d = S_RUN;
            S_RUN: begin
                if (!sprite_enable_update) state_d = S_IDLE;
                else cnt_d = tick ? '0 : cnt_q + 1'b1;
            end
            S_OFF: ;
            default: state_d = S_IDLE;
        endcase

        if (tick && !sprite_write_xy) begin
            step_d = 1'b1;
            if (nx_ok && ny_ok) begin
                x_d      = nx[X_W-1:0];
                y_d      = ny[Y_W-1:0];
                within_d = 1'b1;
            end
`ifdef GAME_SPRITE_BOUNCE_EN
            else if (ny_ok) begin
                x_d      = nx[X_W] ? '0 : X_MAX[X_W-1:0];
                y_d      = ny[Y_W-1:0];
                dx_d     = -dx_q;
                within_d = 1'b1;
            end
`endif
            else begin
                within_d = 1'b0;
                state_d  = S_OFF;
            end
        end

        // A velocity write overrides any bounce reflection computed above.
        if (sprite_write_dxy) begin
            dx_d = sprite_write_dx;
            dy_d = sprite_write_dy;
        end

        if (sprite_write_xy) begin
            x_d      = sprite_write_x;
            y_d      = sprite_write_y;
            within_d = load_ok;
            cnt_d    = '0;
            if (!load_ok) state_d = S_OFF;
            else state_d = sprite_enable_update ? S_RUN : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= X_W'(START_X);
            y_q      <= Y_W'(START_Y);
            dx_q     <= D_W'(START_DX);
            dy_q     <= D_W'(START_DY);
            within_q <= START_OK;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            within_q <= within_d;
            step_q   <= step_d;
        end
    end

    assign sprite_x             = x_q;
    assign sprite_y             = y_q;
    assign sprite_dx            = dx_q;
    assign sprite_dy            = dy_q;
    assign sprite_within_screen = within_q;
    assign sprite_step          = step_q;
endmodule

// File: tb/tb_game_sprite_motion.sv
// Bench for game_sprite_motion: directed test-plan scenarios then random stimulus,
// every cycle compared against an integer reference model of the sprite rules.
module tb_game_sprite_motion;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;
    localparam int STEP_DIV = 4;
    localparam int START_X  = 100;
    localparam int START_Y  = 50;
`ifdef GAME_SPRITE_BOUNCE_EN
    localparam int DX_AFTER = -3;
`else
    localparam int DX_AFTER = 3;
`endif

    logic       clk = 1'b0;
    logic       rst, en, wxy, wdxy;
    logic [9:0] wx, wy;
    logic [3:0] wdx, wdy;
    logic [9:0] sprite_x, sprite_y;
    logic [3:0] sprite_dx, sprite_dy;
    logic       sprite_within_screen, sprite_step;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: 0 idle, 1 running, 2 parked off-screen
    int m_x, m_y, m_dx, m_dy, m_state, m_cnt;
    bit m_within, m_step;

    game_sprite_motion #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
        .X_W(10), .Y_W(10), .D_W(4), .STEP_DIV(STEP_DIV),
        .START_X(START_X), .START_Y(START_Y), .START_DX(0), .START_DY(0)
    ) dut (
        .clk(clk), .rst(rst),
        .sprite_write_xy(wxy), .sprite_write_dxy(wdxy), .sprite_enable_update(en),
        .sprite_write_x(wx), .sprite_write_y(wy), .sprite_write_dx(wdx), .sprite_write_dy(wdy),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_dx(sprite_dx), .sprite_dy(sprite_dy),
        .sprite_within_screen(sprite_within_screen), .sprite_step(sprite_step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sext4(input int v);
        return ((v & 15) ^ 8) - 8;
    endfunction

    function automatic bit in_range(input int x, input int y);
        return (x >= 0) && (x <= SCREEN_W - SPRITE_W) && (y >= 0) && (y <= SCREEN_H - SPRITE_H);
    endfunction

    task automatic model_edge();
        int  nx, ny;
        bit  tick;
        if (!rst) begin
            m_x = START_X; m_y = START_Y; m_dx = 0; m_dy = 0;
            m_within = in_range(START_X, START_Y);
            m_step = 0; m_cnt = 0; m_state = 0;
            return;
        end
        tick   = (m_state == 1) && en && (m_cnt == STEP_DIV - 1);
        nx     = m_x + m_dx;
        ny     = m_y + m_dy;
        m_step = tick && !wxy;
        m_cnt  = (m_state == 1 && en) ? (m_cnt + 1) % STEP_DIV : 0;
        if (m_state == 0 && en) m_state = 1;
        else if (m_state == 1 && !en) m_state = 0;
        if (m_step) begin
            if (in_range(nx, ny)) begin
                m_x = nx; m_y = ny; m_within = 1;
            end
`ifdef GAME_SPRITE_BOUNCE_EN
            else if (ny >= 0 && ny <= SCREEN_H - SPRITE_H) begin
                m_x = (nx < 0) ? 0 : SCREEN_W - SPRITE_W;
                m_y = ny; m_dx = sext4(-m_dx); m_within = 1;
            end
`endif
            else begin
                m_within = 0; m_state = 2;
            end
        end
        if (wdxy) begin
            m_dx = sext4(int'(wdx)); m_dy = sext4(int'(wdy));
        end
        if (wxy) begin
            m_x = int'(wx); m_y = int'(wy); m_cnt = 0;
            m_within = in_range(m_x, m_y);
            m_state = !m_within ? 2 : (en ? 1 : 0);
        end
    endtask

    task automatic compare_all();
        check("x", int'(sprite_x), m_x);
        check("y", int'(sprite_y), m_y);
        check("dx", int'(sprite_dx), m_dx & 15);
        check("dy", int'(sprite_dy), m_dy & 15);
        check("within", int'(sprite_within_screen), int'(m_within));
        check("step", int'(sprite_step), int'(m_step));
    endtask

    task automatic drive(input logic r, input logic e, input logic a, input logic b,
                         input int x, input int y, input int dx, input int dy);
        rst = r; en = e; wxy = a; wdxy = b;
        wx = 10'(x); wy = 10'(y); wdx = 4'(dx); wdy = 4'(dy);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, en, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; wxy = 1'b0; wdxy = 1'b0;
        wx = '0; wy = '0; wdx = '0; wdy = '0;

        // reset and hold with enable low
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        check("rst_x", int'(sprite_x), 100);
        check("rst_y", int'(sprite_y), 50);
        check("rst_within", int'(sprite_within_screen), 1);
        check("rst_step", int'(sprite_step), 0);
        idle_cycles(10);
        check("idle_x", int'(sprite_x), 100);

        // stepping
        drive(1'b1, 1'b0, 1'b1, 1'b1, 10, 10, 2, -1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        idle_cycles(3);
        check("pre_step", int'(sprite_step), 0);
        idle_cycles(1);
        check("step1", int'(sprite_step), 1);
        check("step1_x", int'(sprite_x), 12);
        check("step1_y", int'(sprite_y), 9);
        idle_cycles(4);
        check("step2_x", int'(sprite_x), 14);
        check("step2_y", int'(sprite_y), 8);

        // right-edge exit
        drive(1'b1, 1'b1, 1'b1, 1'b1, 630, 100, 3, 0);
        idle_cycles(4);
        check("edge_step", int'(sprite_step), 1);
`ifdef GAME_SPRITE_BOUNCE_EN
        check("edge_x", int'(sprite_x), 632);
        check("edge_within", int'(sprite_within_screen), 1);
        check("edge_dx", int'(sprite_dx), 13);
`else
        check("edge_x", int'(sprite_x), 630);
        check("edge_within", int'(sprite_within_screen), 0);
        idle_cycles(8);
        check("off_step", int'(sprite_step), 0);
        check("off_x", int'(sprite_x), 630);
`endif

        // re-arm, then write-vs-tick collisions
        drive(1'b1, 1'b1, 1'b1, 1'b1, 20, 20, DX_AFTER, 0);
        check("rearm_within", int'(sprite_within_screen), 1);
        idle_cycles(3);
        check("rearm_pre", int'(sprite_step), 0);
        idle_cycles(1);
        check("rearm_x", int'(sprite_x), 20 + DX_AFTER);
        idle_cycles(3);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5, 5, 0, 0);
        check("coll_xy_x", int'(sprite_x), 5);
        check("coll_xy_step", int'(sprite_step), 0);
        idle_cycles(3);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1, 1);
        check("coll_dxy_x", int'(sprite_x), 5 + DX_AFTER);
        check("coll_dxy_y", int'(sprite_y), 5);
        check("coll_dxy_dx", int'(sprite_dx), 1);
        idle_cycles(4);
        check("newvel_x", int'(sprite_x), 6 + DX_AFTER);
        check("newvel_y", int'(sprite_y), 6);

`ifdef GAME_SPRITE_BOUNCE_EN
        drive(1'b1, 1'b1, 1'b1, 1'b1, 631, 100, 2, 0);
        idle_cycles(4);
        check("bounce_x", int'(sprite_x), 632);
        check("bounce_dx", int'(sprite_dx), 14);
        check("bounce_within", int'(sprite_within_screen), 1);
`endif

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int x, y;
            x = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 700) : $urandom_range(615, 640);
            y = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 520) : $urandom_range(460, 480);
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0),
                  x, y, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
